sens_bram_rd_arbiter: RTL
=========================

SENS_BRAM_RD_ARBITER -- requirements
Module: sens_bram_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 9, sensor BRAM address width {sens[2:0], row[2:0], col[2:0]}.
REQ-002 SHALL have parameter DATA_W, 16, sensor BRAM data width.
REQ-003 SHALL have parameter RD_LAT, 2, BRAM read latency in cycles from registered bram_en to valid bram_dout (legal range 1..4).
REQ-004 SHALL have parameter MAX_BURST, 8, maximum consecutive grants to one requester while another requester is waiting (legal range 1..64).
REQ-005 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 req  in  3  per-requester read request; bit 0 surface IC path, bit 1 plane IC path, bit 2 AXI reader.
REQ-008 addr  in  3*ADDR_W  per-requester read address, slice i = addr[i*ADDR_W +: ADDR_W].
REQ-009 gnt  out  3  one-hot combinational grant; req[i] & gnt[i] in a cycle = one accepted read.
REQ-010 wr_busy  in  1  sensor-frame writer owns the BRAM; blocks new grants.
REQ-011 bram_en  out  1  registered BRAM read enable.
REQ-012 bram_addr  out  ADDR_W  registered BRAM read address.
REQ-013 bram_dout  in  DATA_W  BRAM read data.
REQ-014 rvalid  out  3  one-hot registered read-data valid, tagged to the requester that was granted.
REQ-015 rdata  out  DATA_W  registered read data, shared by all requesters.
REQ-016 busy  out  1  high while any accepted read has not yet returned rvalid.

Function
REQ-017 Requesters SHALL hold req[i] and addr slice stable until gnt[i]; gnt SHALL never be asserted to a requester with req[i]=0.
REQ-018 At most one gnt bit SHALL be high per cycle; no grant SHALL be issued while wr_busy=1 or rst=1.
REQ-019 State SHALL be: owner (none/0/1/2), last_owner (0..2), burst_cnt (0..MAX_BURST).
REQ-020 Owner none: grant the first requester with req=1 searching round-robin from last_owner+1 (mod 3); it becomes owner, burst_cnt=1.
REQ-021 Owner k with req[k]=1 and burst_cnt<MAX_BURST: grant k, burst_cnt+1.
REQ-022 Owner k with req[k]=1, burst_cnt=MAX_BURST, other req pending: grant next round-robin requester after k; it becomes owner, burst_cnt=1, last_owner=k.
REQ-023 Owner k with req[k]=1, burst_cnt=MAX_BURST, no other req: grant k, burst_cnt=1.
REQ-024 Owner k with req[k]=0: owner=none, last_owner=k; in the same cycle arbitrate per REQ-020 (no idle bubble).
REQ-025 wr_busy=1: no grant, owner/burst_cnt/last_owner hold; arbitration resumes in the first cycle wr_busy=0.
REQ-026 On accept of requester i: next cycle bram_en=1, bram_addr=addr slice i; otherwise bram_en=0, bram_addr holds.
REQ-027 A tag pipeline of depth RD_LAT+1 SHALL carry {valid, id}; rvalid[i]=1 and rdata=bram_dout sampled exactly RD_LAT+1 cycles after the registered bram_en cycle, i.e. RD_LAT+2 cycles after the accept cycle.
REQ-028 Back-to-back accepts SHALL sustain one read per cycle with responses returned in accept order; no response dropped or duplicated.
REQ-029 wr_busy rising SHALL NOT cancel reads already accepted; they complete per REQ-027.
REQ-030 busy SHALL be 1 from the cycle after an accept until the cycle the last matching rvalid is asserted, inclusive.
REQ-031 rdata SHALL hold its last value when rvalid=0.

Reset
REQ-032 On rst=1 at a clk edge: gnt=0 (combinationally), bram_en=0, bram_addr=0, rvalid=0, rdata=0, busy=0, owner=none, last_owner=2, burst_cnt=0, tag pipeline cleared.
REQ-033 Reset mid-operation SHALL discard in-flight reads: no rvalid for any read accepted before reset.
REQ-034 First grant after reset with all req=1 SHALL go to requester 0.

Verification
REQ-035 Single read: req=001, addr0=0x1C3, RD_LAT=2 -> gnt=001 cycle 0, bram_en=1/bram_addr=0x1C3 cycle 1, rvalid=001 with rdata=bram_dout cycle 4, busy cycles 1..4.
REQ-036 Fairness: req=111 held, MAX_BURST=8 -> grants 8x req0, 8x req1, 8x req2, repeat; no requester starved beyond 16 cycles.
REQ-037 Solo burst: req=010 held 20 cycles -> 20 consecutive gnt=010, 20 rvalid=010 in order, burst_cnt wraps to 1 without a bubble.
REQ-038 wr_busy: req=100, wr_busy=1 for cycles 3..9 after two accepts -> the two rvalid still arrive, no gnt cycles 3..9, grant resumes cycle 10.
REQ-039 Release/handover: owner 0 drops req while req1=1 -> gnt=010 same cycle, last_owner=0.
REQ-040 Reset mid-burst: rst at cycle 2 of a 5-read burst -> all outputs 0 next cycle, zero rvalid afterward until new accepts, next req=111 grants requester 0.

Source files
------------

// File: rtl/sens_bram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sens_bram_rd_arbiter
// Purpose  : Three-way read arbiter for the sensor BRAM. The arbiter issues
//            one read per cycle. It uses round-robin ownership with a
//            bounded burst length and blocks new grants while the
//            sensor-frame writer owns the BRAM. Read data returns in accept
//            order, tagged one-hot to the requester that issued the read.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            req[2:0]          - read requests (0 surface IC, 1 plane IC, 2 AXI)
//            addr[3*ADDR_W-1:0]- per-requester read addresses
//            gnt[2:0]          - one-hot combinational grant (req&gnt = accept)
//            wr_busy           - writer owns the BRAM, no new grants
//            bram_en/bram_addr - registered BRAM read port
//            bram_dout         - BRAM read data (RD_LAT after bram_en)
//            rvalid[2:0]/rdata - registered, tagged read response
//            busy              - accepted reads still outstanding
// Revision : 1.0 - initial release
// ============================================================================
module sens_bram_rd_arbiter #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 16,
   parameter int RD_LAT    = 2,
   parameter int MAX_BURST = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            req,
   input  logic [3*ADDR_W-1:0]   addr,
   output logic [2:0]            gnt,
   input  logic                  wr_busy,
   output logic                  bram_en,
   output logic [ADDR_W-1:0]     bram_addr,
   input  logic [DATA_W-1:0]     bram_dout,
   output logic [2:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  busy
);

   // Burst counter must be able to hold MAX_BURST itself.
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] C_MAX_BURST = CNT_W'(MAX_BURST);
   localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

   // Owner encoding: requesters 0..2, plus a distinct "none" code.
   localparam logic [1:0] OWN_NONE = 2'd3;
   localparam logic [1:0] LAST_RST = 2'd2;

   // -------------------------------------------------------------------------
   // Address slices
   // -------------------------------------------------------------------------
   logic [ADDR_W-1:0] addr_slice [3];

   for (genvar gi = 0; gi < 3; gi++) begin : g_addr
      assign addr_slice[gi] = addr[gi*ADDR_W +: ADDR_W];
   end

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]        owner_q,      owner_d;
   logic [1:0]        last_owner_q, last_owner_d;
   logic [CNT_W-1:0]  burst_cnt_q,  burst_cnt_d;

   logic              bram_en_q,    bram_en_d;
   logic [ADDR_W-1:0] bram_addr_q,  bram_addr_d;

   // Tag pipeline: stage 0 lines up with the registered bram_en cycle and
   // stage RD_LAT lines up with valid bram_dout.
   logic [RD_LAT:0]   tag_vld_q,    tag_vld_d;
   logic [1:0]        tag_id_q [RD_LAT+1];
   logic [1:0]        tag_id_d [RD_LAT+1];

   logic [2:0]        rvalid_q,     rvalid_d;
   logic [DATA_W-1:0] rdata_q,      rdata_d;

   // -------------------------------------------------------------------------
   // Round-robin helpers
   // -------------------------------------------------------------------------
   function automatic logic [1:0] next3(input logic [1:0] i);
      next3 = (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   // Search base+1, base+2, base+3 (== base) mod 3; returns {found, index}.
   function automatic logic [2:0] rr_pick(input logic [1:0] base,
                                          input logic [2:0] mask);
      logic [1:0] c;
      rr_pick = 3'b000;
      c       = base;
      for (int s = 0; s < 3; s++) begin
         c = next3(c);
         if (mask[c] && !rr_pick[2]) begin
            rr_pick = {1'b1, c};
         end
      end
   endfunction

   // -------------------------------------------------------------------------
   // Arbitration
   // -------------------------------------------------------------------------
   logic [3:0] req_ext;
   logic [3:0] gnt_w;
   logic       own_req;
   logic [1:0] base;
   logic [2:0] pick;
   logic [2:0] others;

   // Padding with a zero lets owner "none" index a request that is never set.
   assign req_ext = {1'b0, req};
   assign own_req = req_ext[owner_q];
   assign others  = (owner_q == OWN_NONE) ? 3'b000
                                          : (req & ~(3'b001 << owner_q));

   always_comb begin
      gnt_w        = 4'b0000;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      burst_cnt_d  = burst_cnt_q;
      base         = last_owner_q;
      pick         = 3'b000;

      if (!rst && !wr_busy) begin
         if (own_req) begin
            if (burst_cnt_q < C_MAX_BURST) begin
               gnt_w[owner_q] = 1'b1;
               burst_cnt_d    = burst_cnt_q + C_ONE;
            end else begin
               // Burst exhausted: hand over if anyone else is waiting,
               // otherwise restart the burst for the same owner.
               pick = rr_pick(owner_q, others);
               if (pick[2]) begin
                  gnt_w[pick[1:0]] = 1'b1;
                  owner_d          = pick[1:0];
                  last_owner_d     = owner_q;
               end else begin
                  gnt_w[owner_q] = 1'b1;
               end
               burst_cnt_d = C_ONE;
            end
         end else begin
            // Owner released (or there was none): re-arbitrate in the same
            // cycle so a release costs no idle bubble.
            if (owner_q != OWN_NONE) begin
               base         = owner_q;
               last_owner_d = owner_q;
            end
            pick = rr_pick(base, req);
            if (pick[2]) begin
               gnt_w[pick[1:0]] = 1'b1;
               owner_d          = pick[1:0];
               burst_cnt_d      = C_ONE;
            end else begin
               owner_d     = OWN_NONE;
               burst_cnt_d = '0;
            end
         end
      end
   end

   assign gnt = gnt_w[2:0];

   // -------------------------------------------------------------------------
   // Read issue and response pipeline
   // -------------------------------------------------------------------------
   logic       accept;
   logic [1:0] gnt_idx;

   // Grants are only ever given to active requesters, so any grant is an accept.
   assign accept  = |gnt;
   assign gnt_idx = gnt[2] ? 2'd2 : (gnt[1] ? 2'd1 : 2'd0);

   always_comb begin
      bram_en_d   = accept;
      bram_addr_d = accept ? addr_slice[gnt_idx] : bram_addr_q;

      tag_vld_d   = {tag_vld_q[RD_LAT-1:0], accept};
      tag_id_d    = tag_id_q;
      tag_id_d[0] = gnt_idx;
      for (int j = 1; j <= RD_LAT; j++) begin
         tag_id_d[j] = tag_id_q[j-1];
      end

      rvalid_d = 3'b000;
      rdata_d  = rdata_q;
      if (tag_vld_q[RD_LAT]) begin
         rvalid_d = 3'b001 << tag_id_q[RD_LAT];
         rdata_d  = bram_dout;
      end
   end

   // -------------------------------------------------------------------------
   // Registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= OWN_NONE;
         last_owner_q <= LAST_RST;
         burst_cnt_q  <= '0;
         bram_en_q    <= 1'b0;
         bram_addr_q  <= '0;
         tag_vld_q    <= '0;
         for (int j = 0; j <= RD_LAT; j++) begin
            tag_id_q[j] <= 2'd0;
         end
         rvalid_q     <= 3'b000;
         rdata_q      <= '0;
      end else begin
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         bram_en_q    <= bram_en_d;
         bram_addr_q  <= bram_addr_d;
         tag_vld_q    <= tag_vld_d;
         tag_id_q     <= tag_id_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
      end
   end

   assign bram_en   = bram_en_q;
   assign bram_addr = bram_addr_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;

   // Outstanding reads live either in the tag pipeline or in the response
   // register; covering both keeps busy high through the last rvalid cycle.
   assign busy = (|tag_vld_q) | (|rvalid_q);

endmodule
`default_nettype wire
